// File: rtl/roc_aer_streamer.sv
// roc_aer_streamer: buffers one image from a valid/ready pixel stream and replays
// it as four-phase AER pixel events, in rank order (descending value) or
// threshold order (ascending index), with an optional end-of-image event.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | nothing loaded, waiting for NEW_IMAGE
// S_LOAD    | accepting pixels into mem[ptr]
// S_WAIT_GO | image complete, ENCODER_RDY high, waiting for START
// S_SCAN    | testing mem[idx] against the current level / threshold
// S_REQ     | pixel event REQ high, waiting for ack_s high
// S_REL     | REQ released, waiting for ack_s low before advancing
// S_EOI_REQ | end-of-image REQ high, waiting for ack_s high
// S_EOI_REL | end-of-image released, waiting for ack_s low
// S_DONE    | image finished, EVT_CNT holds the final count
module roc_aer_streamer #(
  parameter int IMAGE_SIZE = 256,
  parameter int PIXEL_BITS = 8,
  parameter bit ACK_SYNC   = 1'b1,
  parameter bit EOI_EN     = 1'b1,
  localparam int IDX_BITS  = $clog2(IMAGE_SIZE),
  localparam int ADDR_BITS = IDX_BITS + 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  NEW_IMAGE,
  input  logic [PIXEL_BITS-1:0] PIX_DATA,
  input  logic                  PIX_VALID,
  output logic                  PIX_READY,
  input  logic                  MODE,
  input  logic [PIXEL_BITS-1:0] THRESHOLD,
  input  logic                  START,
  output logic                  ENCODER_RDY,
  output logic                  BUSY,
  output logic [IDX_BITS:0]     EVT_CNT,
  output logic [ADDR_BITS-1:0]  AERIN_ADDR,
  output logic                  AERIN_REQ,
  input  logic                  AERIN_ACK
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT_GO, S_SCAN, S_REQ, S_REL, S_EOI_REQ, S_EOI_REL, S_DONE
  } state_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(IMAGE_SIZE - 1);

  state_t                state;
  logic [PIXEL_BITS-1:0] mem [IMAGE_SIZE];
  logic [IDX_BITS-1:0]   ptr;
  logic [IDX_BITS-1:0]   idx;
  logic [PIXEL_BITS-1:0] level;
  logic [PIXEL_BITS-1:0] thr;
  logic                  mode;
  logic                  ack_s;

  logic [PIXEL_BITS-1:0] pix_rd;
  logic [PIXEL_BITS-1:0] thr_in;
  logic                  pix_match;
  logic                  last_idx;
  logic                  more_levels;
  logic                  advance;
  logic                  mem_we;

  generate
    if (ACK_SYNC) begin : g_ack_sync
      logic ack_q1, ack_q2;
      // two-flop synchroniser for the asynchronous acknowledge
      always_ff @(posedge CLK) begin
        if (RST) begin
          ack_q1 <= 1'b0;
          ack_q2 <= 1'b0;
        end else begin
          ack_q1 <= AERIN_ACK;
          ack_q2 <= ack_q1;
        end
      end
      assign ack_s = ack_q2;
    end else begin : g_ack_direct
      assign ack_s = AERIN_ACK;
    end
  endgenerate

  // match test and shared advance rule (SCAN miss, or REL once ack_s is low)
  assign pix_rd      = mem[idx];
  assign thr_in      = (THRESHOLD == '0) ? PIXEL_BITS'(1) : THRESHOLD;
  assign pix_match   = mode ? (pix_rd >= thr) : (pix_rd == level);
  assign last_idx    = (idx == LAST_IDX);
  assign more_levels = !mode && (level > thr);
  assign advance     = ((state == S_SCAN) && !pix_match) || ((state == S_REL) && !ack_s);
  assign mem_we      = (state == S_LOAD) && PIX_VALID && PIX_READY;

  // image buffer write port; contents deliberately not reset
  always_ff @(posedge CLK) begin
    if (mem_we) mem[ptr] <= PIX_DATA;
  end

  // main sequencer with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      ptr         <= '0;
      idx         <= '0;
      level       <= '0;
      thr         <= '0;
      mode        <= 1'b0;
      PIX_READY   <= 1'b0;
      ENCODER_RDY <= 1'b0;
      BUSY        <= 1'b0;
      EVT_CNT     <= '0;
      AERIN_ADDR  <= '0;
      AERIN_REQ   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (NEW_IMAGE) begin
            state     <= S_LOAD;
            ptr       <= '0;
            EVT_CNT   <= '0;
            PIX_READY <= 1'b1;
            BUSY      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (mem_we) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST_IDX) begin
              state       <= S_WAIT_GO;
              PIX_READY   <= 1'b0;
              ENCODER_RDY <= 1'b1;
            end
          end
        end
        S_WAIT_GO: begin
          if (START) begin
            state       <= S_SCAN;
            ENCODER_RDY <= 1'b0;
            mode        <= MODE;
            thr         <= thr_in;
            idx         <= '0;
            level       <= MODE ? thr_in : '1;
          end
        end
        S_SCAN: begin
          if (pix_match) begin
            state      <= S_REQ;
            AERIN_ADDR <= {2'b00, idx};
            AERIN_REQ  <= 1'b1;
          end
        end
        S_REQ: begin
          if (ack_s) begin
            state     <= S_REL;
            AERIN_REQ <= 1'b0;
            EVT_CNT   <= EVT_CNT + 1'b1;
          end
        end
        S_EOI_REQ: begin
          if (ack_s) begin
            state     <= S_EOI_REL;
            AERIN_REQ <= 1'b0;
          end
        end
        S_EOI_REL: begin
          if (!ack_s) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
          end
        end
        default: ;
      endcase

      if (advance) begin
        if (!last_idx) begin
          idx   <= idx + 1'b1;
          state <= S_SCAN;
        end else begin
          idx <= '0;
          if (more_levels) begin
            level <= level - 1'b1;
            state <= S_SCAN;
          end else if (EOI_EN) begin
            state      <= S_EOI_REQ;
            AERIN_ADDR <= '1;
            AERIN_REQ  <= 1'b1;
          end else begin
            state <= S_DONE;
            BUSY  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_roc_aer_streamer.sv
// Directed bench: a 4-pixel instance for ordering, handshake and reset checks,
// and a 256-pixel instance for randomised-backpressure loading.
module tb_roc_aer_streamer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, NEW4, NEW256, PIX_VALID, MODE, START;
  logic [7:0] PIX_DATA, THRESHOLD;
  logic       man_ack, auto_ack;

  logic       rdy4, erdy4, busy4, req4, ack4;
  logic [2:0] cnt4;
  logic [3:0] addr4;
  logic       rdy256, erdy256, busy256, req256, ack256;
  logic [8:0] cnt256;
  logic [9:0] addr256;

  assign ack4   = auto_ack ? req4 : man_ack;
  assign ack256 = req256;

  roc_aer_streamer #(.IMAGE_SIZE(4), .PIXEL_BITS(8), .ACK_SYNC(1'b1), .EOI_EN(1'b1)) dut4 (
    .CLK(CLK), .RST(RST), .NEW_IMAGE(NEW4), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
    .PIX_READY(rdy4), .MODE(MODE), .THRESHOLD(THRESHOLD), .START(START),
    .ENCODER_RDY(erdy4), .BUSY(busy4), .EVT_CNT(cnt4), .AERIN_ADDR(addr4),
    .AERIN_REQ(req4), .AERIN_ACK(ack4));

  roc_aer_streamer #(.IMAGE_SIZE(256), .PIXEL_BITS(8), .ACK_SYNC(1'b1), .EOI_EN(1'b1)) dut256 (
    .CLK(CLK), .RST(RST), .NEW_IMAGE(NEW256), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
    .PIX_READY(rdy256), .MODE(MODE), .THRESHOLD(THRESHOLD), .START(START),
    .ENCODER_RDY(erdy256), .BUSY(busy256), .EVT_CNT(cnt256), .AERIN_ADDR(addr256),
    .AERIN_REQ(req256), .AERIN_ACK(ack256));

  int errors = 0;
  int checks = 0;

  logic [3:0] ev4 [$];
  logic [9:0] ev256 [$];
  logic       prev4 = 1'b0, prev256 = 1'b0;
  logic [7:0] img4 [4];

  // record the address of every rising REQ
  always @(posedge CLK) begin
    #1;
    if (req4 && !prev4) ev4.push_back(addr4);
    if (req256 && !prev256) ev256.push_back(addr256);
    prev4   = req4;
    prev256 = req256;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load4();
    NEW4 = 1'b1;
    tick();
    NEW4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      PIX_VALID = 1'b1;
      PIX_DATA  = img4[i];
      tick();
    end
    PIX_VALID = 1'b0;
  endtask

  task automatic start4(input logic m, input logic [7:0] t);
    START = 1'b1; MODE = m; THRESHOLD = t;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_idle4(input int budget);
    int n = 0;
    while (busy4 && n < budget) begin tick(); n++; end
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; NEW4 = 0; NEW256 = 0; PIX_VALID = 0; MODE = 0; START = 0;
    PIX_DATA = 0; THRESHOLD = 0; man_ack = 0; auto_ack = 1;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    checks++;
    if ({rdy4, erdy4, busy4, req4} !== 4'b0 || addr4 !== 4'h0 || cnt4 !== 3'd0) begin
      errors++;
      $display("FAIL reset4: rdy/erdy/busy/req=%b addr=%h cnt=%0d, required all zero",
               {rdy4, erdy4, busy4, req4}, addr4, cnt4);
    end
    checks++;
    if ({rdy256, erdy256, busy256, req256} !== 4'b0 || addr256 !== 10'h0 || cnt256 !== 9'd0) begin
      errors++;
      $display("FAIL reset256: rdy/erdy/busy/req=%b addr=%h cnt=%0d, required all zero",
               {rdy256, erdy256, busy256, req256}, addr256, cnt256);
    end
  endtask

  task automatic check_events4(input string name, input logic [3:0] exp [$], input int exp_cnt);
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: BUSY=%b, required 0", name, busy4);
    end
    checks++;
    if (ev4.size() !== exp.size()) begin
      errors++;
      $display("FAIL %s_nevents: got %0d events, required %0d", name, ev4.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < ev4.size(); i++) begin
      checks++;
      if (ev4[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_event%0d: addr=%h, required %h", name, i, ev4[i], exp[i]);
      end
    end
    checks++;
    if (cnt4 !== 3'(exp_cnt) || erdy4 !== 1'b0 || req4 !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: EVT_CNT=%0d ERDY=%b REQ=%b, required %0d 0 0",
               name, cnt4, erdy4, req4, exp_cnt);
    end
  endtask

  task automatic test_rank_order();
    logic [3:0] exp [$];
    auto_ack = 1'b1;
    img4 = '{8'd10, 8'd200, 8'd10, 8'd0};
    load4();
    checks++;
    if (erdy4 !== 1'b1 || rdy4 !== 1'b0) begin
      errors++;
      $display("FAIL rank_loaded: ERDY=%b PIX_READY=%b, required 1 0", erdy4, rdy4);
    end
    ev4.delete();
    start4(1'b0, 8'd5);
    wait_idle4(3000);
    exp = '{4'h1, 4'h0, 4'h2, 4'hF};
    check_events4("rank", exp, 3);
  endtask

  task automatic test_threshold_order();
    logic [3:0] exp [$];
    img4 = '{8'd10, 8'd200, 8'd10, 8'd0};
    load4();
    checks++;
    if (cnt4 !== 3'd0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL thr_newimage: EVT_CNT=%0d BUSY=%b, required 0 1", cnt4, busy4);
    end
    ev4.delete();
    start4(1'b1, 8'd10);
    wait_idle4(500);
    exp = '{4'h0, 4'h1, 4'h2, 4'hF};
    check_events4("thr", exp, 3);
  endtask

  task automatic test_zero_threshold();
    logic [3:0] exp [$];
    img4 = '{8'd0, 8'd0, 8'd0, 8'd0};
    load4();
    ev4.delete();
    start4(1'b0, 8'd0);
    wait_idle4(3000);
    exp = '{4'hF};
    check_events4("zero", exp, 0);
  endtask

  task automatic test_handshake();
    int n;
    auto_ack = 1'b0; man_ack = 1'b0;
    img4 = '{8'd1, 8'd1, 8'd0, 8'd0};
    load4();
    start4(1'b1, 8'd1);
    n = 0;
    while (!req4 && n < 20) begin tick(); n++; end
    checks++;
    if (req4 !== 1'b1 || addr4 !== 4'h0) begin
      errors++;
      $display("FAIL hs_req_rise: REQ=%b addr=%h, required 1 0", req4, addr4);
    end
    repeat (5) tick();
    man_ack = 1'b1;
    n = 0;
    while (req4 && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL hs_req_fall: REQ fell %0d edges after ACK, required 3", n);
    end
    tick();
    checks++;
    if (req4 !== 1'b0) begin
      errors++;
      $display("FAIL hs_ack_held: REQ=%b while ACK high, required 0", req4);
    end
    man_ack = 1'b0;
    n = 0;
    while (!req4 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 4 || addr4 !== 4'h1) begin
      errors++;
      $display("FAIL hs_next_req: rose %0d edges after ACK low addr=%h, required 4 and 1", n, addr4);
    end
  endtask

  task automatic test_reset_mid_req();
    man_ack = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({req4, busy4, erdy4, rdy4} !== 4'b0 || cnt4 !== 3'd0 || addr4 !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_req: req/busy/erdy/rdy=%b cnt=%0d addr=%h, required all zero",
               {req4, busy4, erdy4, rdy4}, cnt4, addr4);
    end
    RST = 1'b0; man_ack = 1'b0;
    repeat (2) tick();
    NEW4 = 1'b1;
    tick();
    NEW4 = 1'b0;
    checks++;
    if (rdy4 !== 1'b1 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle: PIX_READY=%b BUSY=%b after NEW_IMAGE, required 1 1", rdy4, busy4);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    auto_ack = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    int i = 0, cyc = 0, n = 0;
    logic acc;
    logic [9:0] exp [$];
    NEW256 = 1'b1;
    tick();
    NEW256 = 1'b0;
    while (i < 256 && cyc < 5000) begin
      PIX_VALID = 1'($urandom_range(0, 1));
      PIX_DATA  = 8'(i * 37);
      START     = (cyc == 7) || (cyc == 300);
      acc = PIX_VALID && rdy256;
      tick();
      cyc++;
      if (acc) i++;
      if (i < 256) begin
        checks++;
        if (erdy256 !== 1'b0) begin
          errors++;
          $display("FAIL bp_early_rdy: ENCODER_RDY=%b after %0d writes, required 0", erdy256, i);
        end
      end
    end
    PIX_VALID = 1'b0; START = 1'b0;
    checks++;
    if (i !== 256 || erdy256 !== 1'b1 || rdy256 !== 1'b0) begin
      errors++;
      $display("FAIL bp_loaded: writes=%0d ERDY=%b PIX_READY=%b, required 256 1 0", i, erdy256, rdy256);
    end
    ev256.delete();
    START = 1'b1; MODE = 1'b1; THRESHOLD = 8'd128;
    tick();
    START = 1'b0;
    repeat (10) tick();
    NEW256 = 1'b1;
    tick();
    NEW256 = 1'b0;
    checks++;
    if (rdy256 !== 1'b0 || busy256 !== 1'b1) begin
      errors++;
      $display("FAIL bp_new_in_scan: PIX_READY=%b BUSY=%b, required 0 1", rdy256, busy256);
    end
    while (busy256 && n < 6000) begin tick(); n++; end
    tick();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] v;
      v = 8'(k * 37);
      if (v >= 8'd128) exp.push_back(10'(k));
    end
    exp.push_back(10'h3FF);
    checks++;
    if (busy256 !== 1'b0 || ev256.size() !== exp.size() || cnt256 !== 9'd128) begin
      errors++;
      $display("FAIL bp_events: BUSY=%b events=%0d EVT_CNT=%0d, required 0 %0d 128",
               busy256, ev256.size(), cnt256, exp.size());
    end
    for (int k = 0; k < exp.size() && k < ev256.size(); k++) begin
      checks++;
      if (ev256[k] !== exp[k]) begin
        errors++;
        $display("FAIL bp_event%0d: addr=%h, required %h", k, ev256[k], exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rank_order();
    test_threshold_order();
    test_zero_threshold();
    test_handshake();
    test_reset_mid_req();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
